mips16_mc_ctrl: RTL and testbench

Multi-cycle control unit for the 16-bit MIPS core. It is the issuing end of the ALU interface.
- Fetches an instruction over a req/ack instruction-memory port and decodes it.
- Drives the ALU opcode/funct and operand-select lines, then consumes the ALU zero flag to resolve branches.
- Sequences data-memory access and register writeback.
- Owns the PC and the instruction register.

---
 rtl/mips16_pkg.sv | 45 ++++
 rtl/mips16_imm_ext.sv | 10 +
 rtl/mips16_mc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mips16_mc_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - opcodes, funct codes, field positions and FSM states for the 16-bit MIPS control
package mips16_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_ORI   = 3'b010;
    localparam logic [2:0] OP_SLTI  = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_ILL   = 3'b101;
    localparam logic [2:0] OP_LW    = 3'b110;
    localparam logic [2:0] OP_SW    = 3'b111;

    localparam logic [3:0] FN_SLL = 4'b0000;
    localparam logic [3:0] FN_ADD = 4'b0001;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_AND = 4'b0011;
    localparam logic [3:0] FN_OR  = 4'b0100;
    localparam logic [3:0] FN_XOR = 4'b0101;
    localparam logic [3:0] FN_SLT = 4'b0110;
    localparam logic [3:0] FN_SRL = 4'b0111;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RS_MSB  = 12;
    localparam int RS_LSB  = 10;
    localparam int RT_MSB  = 9;
    localparam int RT_LSB  = 7;
    localparam int RD_MSB  = 6;
    localparam int RD_LSB  = 4;
    localparam int FN_MSB  = 3;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

endpackage

// File: rtl/mips16_imm_ext.sv
// rtl/mips16_imm_ext.sv - 7-bit immediate to 16-bit zero/sign extension
module mips16_imm_ext (
    input  logic [6:0]  imm7,
    input  logic        zero_ext,
    output logic [15:0] imm_ext
);

    assign imm_ext = zero_ext ? {9'b0, imm7} : {{9{imm7[6]}}, imm7};

endmodule

// File: rtl/mips16_mc_ctrl.sv
// rtl/mips16_mc_ctrl.sv - multi-cycle control FSM: fetch, decode, ALU issue, data memory and writeback
module mips16_mc_ctrl
    import mips16_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [2:0]  alu_opcode,
    output logic [3:0]  alu_funct,
    output logic        alu_src_imm,
    output logic [15:0] imm_ext,
    input  logic        alu_zero,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic        rf_wsel_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [15:0] pc,
    output logic        instr_retired,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;

    logic [2:0]  op, rs, rt, rd, wdest;
    logic [3:0]  funct;
    logic [6:0]  imm7;
    logic [15:0] imm_val;
    logic        is_rtype, legal, in_boot;
    logic [2:0]  alu_op_dec;
    logic [3:0]  alu_fn_dec;
    logic        alu_src_dec;

    assign op       = ir_q[OP_MSB:OP_LSB];
    assign rs       = ir_q[RS_MSB:RS_LSB];
    assign rt       = ir_q[RT_MSB:RT_LSB];
    assign rd       = ir_q[RD_MSB:RD_LSB];
    assign funct    = ir_q[FN_MSB:FN_LSB];
    assign imm7     = ir_q[IMM_MSB:IMM_LSB];
    assign is_rtype = (op == OP_RTYPE);
    assign legal    = is_rtype ? ~funct[3] : (op != OP_ILL);
    assign wdest    = is_rtype ? rd : rt;
    assign in_boot  = (state_q == ST_BOOT);

    mips16_imm_ext u_imm_ext (
        .imm7     (imm7),
        .zero_ext (op == OP_ORI),
        .imm_ext  (imm_val)
    );

    // ALU lines are a pure decode of ir so they stay stable from EXEC through WB
    always_comb begin
        alu_op_dec  = OP_RTYPE;
        alu_fn_dec  = FN_SLL;
        alu_src_dec = 1'b0;
        if (legal) begin
            case (op)
                OP_RTYPE: alu_fn_dec = funct;
                OP_BEQ:   alu_fn_dec = FN_SUB;
                default: begin
                    alu_op_dec  = op;
                    alu_src_dec = 1'b1;
                end
            endcase
        end
    end

    assign alu_opcode  = in_boot ? 3'b0 : alu_op_dec;
    assign alu_funct   = in_boot ? 4'b0 : alu_fn_dec;
    assign alu_src_imm = ~in_boot & alu_src_dec;
    assign imm_ext     = in_boot ? 16'b0 : imm_val;
    assign rf_raddr1   = in_boot ? 3'b0 : rs;
    assign rf_raddr2   = in_boot ? 3'b0 : rt;
    assign rf_waddr    = in_boot ? 3'b0 : wdest;
    assign rf_wsel_mem = ~in_boot & (op == OP_LW);
    assign imem_addr   = in_boot ? 16'b0 : pc_q;
    assign pc          = in_boot ? 16'b0 : pc_q;
    assign illegal     = illegal_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        illegal_d     = illegal_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        rf_we         = 1'b0;
        instr_retired = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (legal) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (op == OP_BEQ) begin
                    // pc already points past the branch, so the offset is relative to PC+1
                    if (alu_zero) pc_d = pc_q + imm_val;
                    instr_retired = 1'b1;
                    state_d       = ST_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_SW);
                if (dmem_ack) begin
                    if (op == OP_SW) begin
                        instr_retired = 1'b1;
                        state_d       = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we         = (wdest != 3'd0);
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            ir_q      <= 16'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_mips16_mc_ctrl.sv
// tb/tb_mips16_mc_ctrl.sv - randomized and directed bench for mips16_mc_ctrl against a phase-plan model
module tb_mips16_mc_ctrl;

    localparam logic [15:0] TB_RESET_PC = 16'h0040;
    localparam int P_BOOT = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_TRAP = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_funct;
    logic        alu_src_imm, alu_zero;
    logic [15:0] imm_ext, pc;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        rf_we, rf_wsel_mem, dmem_req, dmem_we, dmem_ack, instr_retired, illegal;

    mips16_mc_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
        .alu_zero(alu_zero), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wsel_mem(rf_wsel_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .pc(pc), .instr_retired(instr_retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: each instruction is a list of phases chosen by its opcode
    int          m_phase;
    logic        m_valid = 1'b0;
    logic [15:0] m_pc, m_ir;
    logic        m_ill;
    int          plan[$];

    logic [2:0]  op_m, e_op, wdest_m;
    logic [3:0]  fn_m, e_fn;
    logic        e_src, legal_m, boot_m;
    logic [15:0] e_imm;
    int          iv;

    int cyc_cnt = 0, ack_cyc = 0, retire_cyc = 0;
    int retire_cnt = 0, we_cnt = 0, req_cnt = 0, dreq_cnt = 0, dwe_cnt = 0;
    logic [15:0] fetch_log[$];
    logic [2:0]  x_op;
    logic [3:0]  x_fn;
    logic        x_src, w_we, w_sel;
    logic [15:0] x_imm;
    logic [2:0]  w_addr;

    always @(negedge clk) begin
        cyc_cnt++;
        if (m_valid) begin
            op_m    = m_ir[15:13];
            fn_m    = m_ir[3:0];
            legal_m = !(op_m == 3'd5 || (op_m == 3'd0 && fn_m >= 4'd8));
            iv      = int'(m_ir[6:0]);
            if (op_m != 3'd2 && iv >= 64) iv -= 128;
            e_imm   = 16'(iv);
            wdest_m = (op_m == 3'd0) ? m_ir[6:4] : m_ir[9:7];
            e_op = 3'd0; e_fn = 4'd0; e_src = 1'b0;
            if (legal_m) begin
                if (op_m == 3'd0) e_fn = fn_m;
                else if (op_m == 3'd4) e_fn = 4'd2;
                else begin e_op = op_m; e_src = 1'b1; end
            end
            boot_m = (m_phase == P_BOOT);
            chk("imem_req", imem_req, m_phase == P_FETCH);
            chk("imem_addr", imem_addr, boot_m ? 16'd0 : m_pc);
            chk("pc", pc, boot_m ? 16'd0 : m_pc);
            chk("alu_opcode", alu_opcode, boot_m ? 3'd0 : e_op);
            chk("alu_funct", alu_funct, boot_m ? 4'd0 : e_fn);
            chk("alu_src_imm", alu_src_imm, !boot_m && e_src);
            chk("imm_ext", imm_ext, boot_m ? 16'd0 : e_imm);
            chk("rf_raddr1", rf_raddr1, boot_m ? 3'd0 : m_ir[12:10]);
            chk("rf_raddr2", rf_raddr2, boot_m ? 3'd0 : m_ir[9:7]);
            chk("rf_we", rf_we, m_phase == P_WB && wdest_m != 3'd0);
            chk("rf_waddr", rf_waddr, boot_m ? 3'd0 : wdest_m);
            chk("rf_wsel_mem", rf_wsel_mem, !boot_m && op_m == 3'd6);
            chk("dmem_req", dmem_req, m_phase == P_MEM);
            chk("dmem_we", dmem_we, m_phase == P_MEM && op_m == 3'd7);
            chk("instr_retired", instr_retired, m_phase == P_WB || (m_phase == P_EXEC && op_m == 3'd4)
                || (m_phase == P_MEM && op_m == 3'd7 && dmem_ack));
            chk("illegal", illegal, m_ill);

            if (imem_req && imem_ack) begin fetch_log.push_back(imem_addr); ack_cyc = cyc_cnt; end
            if (instr_retired) begin retire_cnt++; retire_cyc = cyc_cnt; end
            if (rf_we) we_cnt++;
            if (imem_req) req_cnt++;
            if (dmem_req) dreq_cnt++;
            if (dmem_we) dwe_cnt++;
            if (m_phase == P_EXEC) begin x_op = alu_opcode; x_fn = alu_funct; x_src = alu_src_imm; x_imm = imm_ext; end
            if (m_phase == P_WB) begin w_we = rf_we; w_addr = rf_waddr; w_sel = rf_wsel_mem; end
        end

        if (rst) begin
            m_valid = 1'b1; m_phase = P_BOOT; m_pc = TB_RESET_PC; m_ir = 16'd0; m_ill = 1'b0;
            plan.delete();
        end else if (m_valid) begin
            case (m_phase)
                P_BOOT: m_phase = P_FETCH;
                P_FETCH: if (imem_ack) begin
                    m_ir = imem_rdata; m_pc = m_pc + 16'd1; m_phase = P_DECODE;
                end
                P_DECODE: begin
                    if (!legal_m) begin
                        m_ill = 1'b1; m_phase = P_TRAP;
                    end else begin
                        case (op_m)
                            3'd6:    plan = '{P_EXEC, P_MEM, P_WB};
                            3'd7:    plan = '{P_EXEC, P_MEM};
                            3'd4:    plan = '{P_EXEC};
                            default: plan = '{P_EXEC, P_WB};
                        endcase
                        m_phase = plan.pop_front();
                    end
                end
                P_TRAP: m_phase = P_TRAP;
                default: if (!(m_phase == P_MEM && !dmem_ack)) begin
                    if (m_phase == P_EXEC && op_m == 3'd4 && alu_zero) m_pc = m_pc + e_imm;
                    m_phase = (plan.size() > 0) ? plan.pop_front() : P_FETCH;
                end
            endcase
        end
    end

    int zmode = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
        alu_zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!imem_req && n < 40) begin cyc(); n++; end
        chk("fetch_wait", imem_req, 1);
    endtask

    task automatic fetch(input logic [15:0] instr, input int fdly);
        wait_fetch();
        repeat (fdly) cyc();
        imem_ack = 1'b1; imem_rdata = instr;
        cyc();
        imem_ack = 1'b0; imem_rdata = 16'($urandom);
    endtask

    task automatic run_instr(input logic [15:0] instr, input int fdly, input int mdly);
        int n = 0;
        fetch(instr, fdly);
        if (instr[15:14] == 2'b11) begin
            while (!dmem_req && n < 10) begin cyc(); n++; end
            chk("dmem_wait", dmem_req, 1);
            repeat (mdly) cyc();
            dmem_ack = 1'b1;
            cyc();
            dmem_ack = 1'b0;
        end
    endtask

    task automatic wait_retire(input int prev);
        int n = 0;
        while (retire_cnt == prev && n < 20) begin cyc(); n++; end
        chk("retire_wait", retire_cnt, prev + 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, q0, dq0, dw0, we0;
        int off;
        logic [2:0]  ops[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        logic [2:0]  rop;
        logic [15:0] ins;

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'd0; alu_zero = 1'b0; dmem_ack = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        // add r3,r1,r2 with a 3-cycle fetch stall
        r0 = retire_cnt; q0 = req_cnt;
        fetch(16'h0531, 3);
        chk("first_fetch_addr", fetch_log[0], 16'h0040);
        chk("boot_quiet", we_cnt + dreq_cnt, 0);
        chk("add_req_hold", req_cnt - q0, 4);
        wait_retire(r0);
        chk("add_exec_op", x_op, 3'd0);
        chk("add_exec_fn", x_fn, 4'd1);
        chk("add_exec_src", x_src, 1'b0);
        chk("add_wb_we", w_we, 1'b1);
        chk("add_wb_addr", w_addr, 3'd3);
        chk("add_latency", retire_cyc - ack_cyc + 1, 4);

        // lw r2,-1(r1) with a 2-cycle data stall
        r0 = retire_cnt; dq0 = dreq_cnt; dw0 = dwe_cnt;
        run_instr(16'hC57F, 0, 2);
        wait_retire(r0);
        chk("lw_imm", x_imm, 16'hFFFF);
        chk("lw_src", x_src, 1'b1);
        chk("lw_dreq_hold", dreq_cnt - dq0, 3);
        chk("lw_no_we", dwe_cnt - dw0, 0);
        chk("lw_wb_sel", w_sel, 1'b1);
        chk("lw_wb_addr", w_addr, 3'd2);

        r0 = retire_cnt;
        run_instr(16'hC57F, 0, 0);
        wait_retire(r0);
        chk("lw_latency", retire_cyc - ack_cyc + 1, 5);

        // sw r2,3(r1)
        r0 = retire_cnt; dw0 = dwe_cnt;
        run_instr(16'hE503, 0, 0);
        wait_retire(r0);
        chk("sw_latency", retire_cyc - ack_cyc + 1, 4);
        chk("sw_we_cycles", dwe_cnt - dw0, 1);

        // taken beq steering the PC to 0010
        zmode = 1;
        wait_fetch();
        off = 16 - (int'(m_pc) + 1);
        r0 = retire_cnt;
        run_instr({3'b100, 3'd1, 3'd2, 7'(off)}, 0, 0);
        wait_retire(r0);
        chk("beq_latency", retire_cyc - ack_cyc + 1, 3);

        r0 = retire_cnt;
        run_instr(16'h817E, 0, 0);
        chk("beq_t_pc", fetch_log[$], 16'h0010);
        wait_retire(r0);
        chk("beq_t_fn", x_fn, 4'd2);
        chk("beq_t_op", x_op, 3'd0);

        // addi r0 at the branch target
        zmode = 0;
        r0 = retire_cnt; we0 = we_cnt;
        run_instr(16'h2405, 0, 0);
        chk("beq_t_target", fetch_log[$], 16'h000F);
        wait_retire(r0);
        chk("addi_r0_no_we", we_cnt - we0, 0);
        chk("addi_r0_wb_we", w_we, 1'b0);

        r0 = retire_cnt;
        run_instr(16'h817E, 0, 0);
        chk("beq_nt_pc", fetch_log[$], 16'h0010);
        wait_retire(r0);
        chk("beq_nt_fn", x_fn, 4'd2);

        r0 = retire_cnt;
        run_instr(16'h427F, 0, 0);
        chk("beq_nt_target", fetch_log[$], 16'h0011);
        wait_retire(r0);
        chk("ori_zero_ext", x_imm, 16'h007F);
        chk("ori_wb_addr", w_addr, 3'd4);

        // randomized legal instruction stream
        zmode = 2;
        r0 = retire_cnt;
        for (int i = 0; i < 60; i++) begin
            rop = ops[$urandom_range(0, 6)];
            if (rop == 3'd0)
                ins = {3'd0, 3'($urandom), 3'($urandom), 3'($urandom), 1'b0, 3'($urandom)};
            else
                ins = {rop, 3'($urandom), 3'($urandom), 7'($urandom)};
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        for (int n = 0; n < 20 && retire_cnt != r0 + 60; n++) cyc();
        chk("random_retire_count", retire_cnt - r0, 60);

        // reset while a load/store is pending, followed by a late ack
        zmode = 0;
        fetch(16'hE503, 0);
        for (int n = 0; n < 10 && !dmem_req; n++) cyc();
        cyc(); cyc();
        r0 = retire_cnt;
        rst = 1'b1;
        cyc();
        chk("rst_dmem_drop", dmem_req, 1'b0);
        rst = 1'b0; dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        chk("rst_no_retire", retire_cnt, r0);
        r0 = retire_cnt;
        run_instr(16'h0531, 0, 0);
        chk("rst_restart_pc", fetch_log[$], 16'h0040);
        wait_retire(r0);

        // undefined opcode 101
        r0 = retire_cnt;
        run_instr(16'hA000, 0, 0);
        q0 = req_cnt;
        repeat (8) cyc();
        chk("ill_op_flag", illegal, 1'b1);
        chk("ill_op_no_req", req_cnt - q0, 0);
        chk("ill_op_no_retire", retire_cnt, r0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("ill_cleared", illegal, 1'b0);
        r0 = retire_cnt;
        run_instr(16'h0531, 0, 0);
        chk("ill_restart_pc", fetch_log[$], 16'h0040);
        wait_retire(r0);

        // undefined R-type funct 1000
        run_instr(16'h0008, 1, 0);
        repeat (5) cyc();
        chk("ill_fn_flag", illegal, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
